hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage CPU.
- Each cycle it decides which of the following the pipeline does:
  - inserts a bubble (drives the ID-stage control-zeroing mux select);
  - freezes PC and IF/ID for a load-use hazard;
  - freezes the whole pipeline while data memory is busy;
  - flushes IF/ID on a taken branch.
- Holds a small FSM for multi-cycle memory waits, a wait timeout, and a stall-cycle performance counter.

Parameters:
- CNT_W, 16: width of the stall_cycles_o performance counter.
- MEM_TIMEOUT, 64: number of consecutive MEM_WAIT cycles after which the block enters HALT.
- TMO_W, 8: width of the internal wait counter. Must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ifid_rs_i  in  5  rs field of the instruction in ID.
- ifid_rt_i  in  5  rt field of the instruction in ID.
- idex_rt_i  in  5  destination rt of the instruction in EX.
- idex_memread_i  in  1  instruction in EX is a load.
- branch_taken_i  in  1  ID-stage branch resolved taken.
- dmem_req_i  in  1  MEM stage is issuing a data memory access.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID register write enable.
- ifid_flush_o  out  1  clear IF/ID to a NOP.
- bubble_o  out  1  select for the ID control mux; 1 zeroes WB/MEM/EX control.
- pipe_stall_o  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- timeout_o  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT.
- stall_cycles_o  out  CNT_W  count of cycles with pc_write_o=0.

Behaviour:
- State is registered. Outputs are Mealy: combinational from state and current inputs, so they act in the same cycle as the hazard.
- States: RUN, LU_HOLD, MEM_WAIT, HALT.
- Load-use hazard (lu):
  - lu = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i)).
- Memory wait (mw):
  - mw = dmem_req_i & ~dmem_ack_i.
- Default outputs: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, bubble_o=0, pipe_stall_o=0.
- Priority when events coincide: mw > lu > branch_taken_i.
- RUN:
  - if mw: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, bubble_o=0, flush suppressed; next state MEM_WAIT, wait counter = 1.
  - else if lu: pc_write_o=0, ifid_write_o=0, bubble_o=1, flush suppressed; next state LU_HOLD.
  - else if branch_taken_i: ifid_flush_o=1 for this cycle only; stay in RUN.
- LU_HOLD (exactly one cycle):
  - lu is masked, because the bubble is already in EX.
  - mw and branch_taken_i are handled as in RUN.
  - Next state is RUN, or MEM_WAIT if mw.
  - Two back-to-back lu stalls for the same instruction never occur.
- MEM_WAIT:
  - Outputs: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1; branch_taken_i is ignored (frozen, re-seen on release).
  - On dmem_ack_i=1: release in the same cycle (default outputs, lu and branch evaluated as in RUN); next state RUN, or LU_HOLD if lu.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT with no ack, next state is HALT and timeout_o is set to 1.
- HALT:
  - Outputs: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, bubble_o=1.
  - Remains in HALT until rst_i. timeout_o stays 1.
- stall_cycles_o:
  - Increments on every cycle where pc_write_o=0, including HALT.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset (rst_i=1 at an edge, including mid-MEM_WAIT):
  - state=RUN, wait counter=0, timeout_o=0, stall_cycles_o=0.
  - While rst_i=1, outputs are forced: pc_write_o=0, ifid_write_o=0, bubble_o=1, pipe_stall_o=0, ifid_flush_o=0.
  - The counter does not count reset cycles.

Test Plan:
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 -> that cycle pc_write_o=0, ifid_write_o=0, bubble_o=1; next cycle (LU_HOLD, inputs unchanged) pc_write_o=1, bubble_o=0; stall_cycles_o=1.
- Register zero: idex_memread_i=1, idex_rt_i=0, ifid_rt_i=0 -> no stall, all defaults.
- Memory wait: dmem_req_i=1, dmem_ack_i=0 for 3 cycles, then ack -> pipe_stall_o=1 for 3 cycles, released on the ack cycle; stall_cycles_o=3.
- Simultaneous events: mw, lu and branch_taken_i all 1 -> pipe_stall_o=1, bubble_o=0, ifid_flush_o=0. After ack with lu still 1 -> bubble_o=1, then LU_HOLD.
- Taken branch alone in RUN -> ifid_flush_o=1 for exactly one cycle, pc_write_o=1.
- Timeout: MEM_TIMEOUT=4, ack never arrives -> HALT entered after 4 wait cycles, timeout_o=1 sticky. rst_i=1 for one edge -> state RUN, timeout_o=0, stall_cycles_o=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / memory-wait / branch-flush stall sequencer with wait timeout and stall counter
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TMO_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             bubble_o,
    output logic             pipe_stall_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);
    typedef enum logic [1:0] {RUN, LU_HOLD, MEM_WAIT, HALT} state_t;
    state_t           r_state;
    state_t           w_next;
    logic [TMO_W-1:0] r_wcnt;
    logic [TMO_W-1:0] w_wcnt_next;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu;
    logic             w_mw;
    logic             w_hold_mem;
    logic             w_take_lu;
    logic             w_take_br;
    logic             w_tmo_hit;
    assign w_lu = idex_memread_i & (idex_rt_i != 5'd0) & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    assign w_mw = dmem_req_i & ~dmem_ack_i;
    assign timeout_o      = r_timeout;
    assign stall_cycles_o = r_stall_cnt;
    // resolve which event wins this cycle: memory hold > load-use > branch; lu masked in LU_HOLD
    always_comb begin
        w_hold_mem = (r_state == HALT) | ((r_state == MEM_WAIT) ? ~dmem_ack_i : w_mw);
        w_take_lu  = ~w_hold_mem & w_lu & ((r_state == RUN) | (r_state == MEM_WAIT));
        w_take_br  = ~w_hold_mem & ~w_take_lu & branch_taken_i;
        w_tmo_hit  = (r_state == MEM_WAIT) & ~dmem_ack_i & ((r_wcnt + TMO_W'(1)) >= TMO_W'(MEM_TIMEOUT));
    end
    // state register with wait counter and sticky timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= RUN;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wcnt    <= w_wcnt_next;
            r_timeout <= r_timeout | w_tmo_hit;
        end
    end
    // next state and next wait count; the first stalled cycle counts as wait cycle 1
    always_comb begin
        w_next      = ((r_state == HALT) | w_tmo_hit) ? HALT : w_hold_mem ? MEM_WAIT : w_take_lu ? LU_HOLD : RUN;
        w_wcnt_next = (r_state == HALT) ? r_wcnt : w_hold_mem ? (((r_state == MEM_WAIT) ? r_wcnt : '0) + TMO_W'(1)) : '0;
    end
    // Mealy pipeline controls; reset forces a frozen front end with a bubble
    always_comb begin
        pc_write_o   = ~rst_i & ~(w_hold_mem | w_take_lu);
        ifid_write_o = ~rst_i & ~(w_hold_mem | w_take_lu);
        ifid_flush_o = ~rst_i & w_take_br;
        bubble_o     = rst_i | w_take_lu | (r_state == HALT);
        pipe_stall_o = ~rst_i & w_hold_mem;
    end
    // saturating count of cycles where the PC is held, excluding reset
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (~pc_write_o & ~&r_stall_cnt)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_hazard_stall_ctrl;
    localparam int CW = 3;
    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          idex_memread, branch_taken, dmem_req, dmem_ack;
    logic          pc_write, ifid_write, ifid_flush, bubble, pipe_stall, timeout;
    logic [CW-1:0] stall_cycles;
    typedef struct {
        logic [8:0] e;
        string      nm;
    } exp_t;
    exp_t       q[$];
    exp_t       x;
    int         total = 0;
    int         bad = 0;
    logic [8:0] w_act;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4), .TMO_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .idex_rt_i(idex_rt),
        .idex_memread_i(idex_memread), .branch_taken_i(branch_taken),
        .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .bubble_o(bubble), .pipe_stall_o(pipe_stall), .timeout_o(timeout),
        .stall_cycles_o(stall_cycles)
    );

    assign w_act = {pc_write, ifid_write, ifid_flush, bubble, pipe_stall, timeout, stall_cycles};

    function automatic logic [8:0] ex(input logic pc, input logic iw, input logic fl, input logic bu,
                                      input logic st, input logic to, input logic [2:0] c);
        return {pc, iw, fl, bu, st, to, c};
    endfunction

    // expected values are pushed by stimulus; this monitor checks them mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            total++;
            if (w_act !== x.e) begin
                bad++;
                $display("FAIL %s: {pc,ifw,flush,bub,stall,tmo,cnt} got %b want %b", x.nm, w_act, x.e);
            end
        end
    end

    task automatic cyc(input logic r, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic req, input logic ack,
                       input logic [8:0] e, input string nm);
        exp_t t;
        @(posedge clk);
        #1;
        rst = r; idex_memread = mr; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
        branch_taken = br; dmem_req = req; dmem_ack = ack;
        t.e = e;
        t.nm = nm;
        q.push_back(t);
    endtask

    initial begin
        rst = 1'b1; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; dmem_req = 0; dmem_ack = 0;
        @(posedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 0), "reset_forced");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0), "idle");
        cyc(0, 1, 5, 5, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 0), "lu_rs");
        cyc(0, 1, 5, 5, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 1), "lu_hold_masked");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 1), "reg_zero");
        cyc(0, 1, 7, 3, 7, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 1), "lu_rt");
        cyc(0, 1, 7, 3, 7, 1, 0, 0, ex(1, 1, 1, 0, 0, 0, 2), "lu_hold_branch");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, ex(1, 1, 1, 0, 0, 0, 2), "branch");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 2), "branch_one_cycle");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 2), "reset2");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 0), "mw1");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 1), "mw2");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 2), "mw3");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, ex(1, 1, 0, 0, 0, 0, 3), "mw_ack_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 3), "after_release");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 3), "reset3");
        cyc(0, 1, 5, 5, 0, 1, 1, 0, ex(0, 0, 0, 0, 1, 0, 0), "all_events");
        cyc(0, 1, 5, 5, 0, 1, 1, 1, ex(0, 0, 0, 1, 0, 0, 1), "ack_then_lu");
        cyc(0, 1, 5, 5, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 2), "lu_hold_after_ack");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 2), "reset4");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 0), "tmo_w1");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 1), "tmo_w2");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 2), "tmo_w3");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 3), "tmo_w4");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, ex(0, 0, 0, 1, 1, 1, 4), "halt_ignores_ack");
        cyc(0, 1, 5, 5, 0, 1, 0, 0, ex(0, 0, 0, 1, 1, 1, 5), "halt_ignores_lu_br");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 1, 1, 6), "halt_cnt6");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 1, 1, 7), "halt_cnt7");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 1, 1, 7), "cnt_saturate");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 1, 7), "reset_from_halt");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0), "after_reset_clear");
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
